// File: rtl/cdot_engine_arbiter.sv
// cdot_engine_arbiter: round-robin front end sharing one complex
// dot-product engine, with in-order steering of engine results.
module cdot_engine_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int SIZE            = 16,
  parameter int WIDTH           = 64,
  parameter int NUM_OPERANDS    = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic [NUM_REQ-1:0]                        req_valid_i,
  output logic [NUM_REQ-1:0]                        req_ready_o,
  input  logic [NUM_REQ-1:0][SIZE*NUM_OPERANDS-1:0][WIDTH-1:0] req_operands_i,
  output logic [NUM_REQ-1:0]                        rsp_valid_o,
  input  logic [NUM_REQ-1:0]                        rsp_ready_i,
  output logic [1:0][WIDTH-1:0]                     rsp_result_o,
  output logic                                      eng_in_valid_o,
  input  logic                                      eng_in_ready_i,
  output logic                                      eng_flush_o,
  output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]   eng_operands_o,
  input  logic                                      eng_out_valid_i,
  output logic                                      eng_out_ready_o,
  input  logic [2*SIZE-1:0][WIDTH-1:0]              eng_result_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding_o,
  output logic                                      busy_o,
  output logic                                      err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e         state_q;
  logic [IW-1:0]  lock_id_q;
  logic [IW-1:0]  rr_ptr_q;
  logic [IW-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q;

  logic           active;
  logic           full;
  logic           empty;
  logic [IW-1:0]  rr_win;
  logic [IW-1:0]  scan;
  logic           found;
  logic [IW-1:0]  grant_id;
  logic [IW-1:0]  head_id;
  logic           issue;
  logic           push;
  logic           pop;
  logic           orphan;
  logic           unused_words;

  function automatic logic [IW-1:0] inc_id(input logic [IW-1:0] x);
    return (x == LAST_ID) ? '0 : x + 1'b1;
  endfunction

  assign active   = rst_ni & ~flush_i;
  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign head_id  = fifo_q[rd_q];
  assign grant_id = (state_q == LOCKED) ? lock_id_q : rr_win;
  assign issue    = active & req_valid_i[grant_id] & ~full;
  assign push     = issue & eng_in_ready_i;
  assign pop      = active & eng_out_valid_i & ~empty
                  & rsp_ready_i[head_id];
  assign orphan   = active & eng_out_valid_i & empty;

  // Scan requesters starting at the round-robin pointer, wrapping.
  always_comb begin
    rr_win = rr_ptr_q;
    scan   = rr_ptr_q;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_i[scan]) begin
        found  = 1'b1;
        rr_win = scan;
      end
      scan = inc_id(scan);
    end
  end

  // Per-requester handshake and result-valid steering.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (push) begin
      req_ready_o[grant_id] = 1'b1;
    end
    if (active && eng_out_valid_i && !empty) begin
      rsp_valid_o[head_id] = 1'b1;
    end
  end

  assign eng_in_valid_o  = issue;
  assign eng_operands_o  = req_operands_i[grant_id];
  assign eng_out_ready_o = active & (empty | rsp_ready_i[head_id]);
  assign eng_flush_o     = rst_ni & flush_i;
  assign rsp_result_o    = {eng_result_i[1], eng_result_i[0]};
  assign outstanding_o   = cnt_q;
  assign busy_o          = rst_ni & (~empty | (|req_valid_i));
  assign err_o           = err_q;
  assign unused_words    = ^eng_result_i;

  // Grant FSM: hold the winner while the engine stalls its bundle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else if (flush_i) begin
      state_q   <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (issue && !eng_in_ready_i) begin
            state_q   <= LOCKED;
            lock_id_q <= rr_win;
          end
        end
        LOCKED: begin
          if (push) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Round-robin pointer moves past each accepted requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (flush_i) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= inc_id(grant_id);
    end
  end

  // In-order tracking FIFO of issuer IDs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= grant_id;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Sticky flag for results arriving with nothing tracked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (orphan) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdot_engine_arbiter.sv
// tb_cdot_engine_arbiter: directed and random traffic checked against
// a queue-level reference of arbitration, tracking and routing.
module tb_cdot_engine_arbiter;

  localparam int NR   = 4;
  localparam int SZ   = 16;
  localparam int W    = 64;
  localparam int NO   = 4;
  localparam int MAXO = 8;
  localparam int LAT  = 3;
  localparam int NW   = SZ * NO;

  typedef logic [NW-1:0][W-1:0] op_t;
  typedef struct {
    int         id;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } trk_t;
  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           due;
  } eng_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR-1:0][NW-1:0][W-1:0] bundles = '0;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready = '0;
  logic [1:0][W-1:0] rsp_result;
  logic eng_in_valid;
  logic eng_in_ready = 1'b0;
  logic eng_flush;
  logic [NW-1:0][W-1:0] eng_ops;
  logic eng_out_valid = 1'b0;
  logic eng_out_ready;
  logic [2*SZ-1:0][W-1:0] eng_result = '0;
  logic [3:0] outstanding;
  logic busy;
  logic err;

  cdot_engine_arbiter #(
    .NUM_REQ(NR), .SIZE(SZ), .WIDTH(W),
    .NUM_OPERANDS(NO), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_operands_i (bundles),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_result_o   (rsp_result),
    .eng_in_valid_o (eng_in_valid),
    .eng_in_ready_i (eng_in_ready),
    .eng_flush_o    (eng_flush),
    .eng_operands_o (eng_ops),
    .eng_out_valid_i(eng_out_valid),
    .eng_out_ready_o(eng_out_ready),
    .eng_result_i   (eng_result),
    .outstanding_o  (outstanding),
    .busy_o         (busy),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs
  bit auto_req = 0;
  int vprob = 0;
  int inr_pct = 100;
  int rspr_pct = 100;
  int outv_pct = 100;
  int flush_pm = 0;
  bit force_flush = 0;
  bit orphan_now = 0;
  logic [NR-1:0] hold_mask = '0;
  logic [NR-1:0] nv = '0;
  bit nv_en = 0;
  bit ph_single = 0;

  // reference and environment state
  trk_t mq[$];
  int rr_m = 0;
  bit lock_m = 0;
  int lockid_m = 0;
  bit err_m = 0;
  eng_t epipe[$];
  bit out_hold = 0;
  int cyc = 0;
  logic [NR-1:0] acc = '0;
  int glog[$];
  int pulses0 = 0;
  int single_seen = 0;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic trk_t mkexp(input int id, input op_t b);
    real sr, si, ar, ai, br, bi;
    trk_t t;
    sr = 0.0;
    si = 0.0;
    for (int e = 0; e < SZ; e++) begin
      ar = $bitstoreal(b[NO*e]);
      ai = $bitstoreal(b[NO*e+1]);
      br = $bitstoreal(b[NO*e+2]);
      bi = $bitstoreal(b[NO*e+3]);
      sr = sr + ar * br - ai * bi;
      si = si + ar * bi + ai * br;
    end
    t.id = id;
    t.re = $realtobits(sr);
    t.im = $realtobits(si);
    return t;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return p;
  endfunction

  task automatic new_bundle(input int r);
    for (int k = 0; k < NW; k++) begin
      bundles[r][k] = $realtobits(real'(int'($urandom_range(0, 6)) - 3));
    end
  endtask

  task automatic step();
    bit any_v, iss, pu, emp, po;
    int g, hd;
    logic [NR-1:0] exp_rdy, exp_rv;
    eng_t e;
    trk_t t;
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (acc[r]) begin
        new_bundle(r);
        req_valid[r] = auto_req ? ($urandom_range(0, 99) < vprob)
                                : hold_mask[r];
      end else if (auto_req && !req_valid[r] &&
                   $urandom_range(0, 99) < vprob) begin
        new_bundle(r);
        req_valid[r] = 1'b1;
      end
      rsp_ready[r] = ($urandom_range(0, 99) < rspr_pct);
    end
    if (nv_en) begin
      req_valid = nv;
      nv_en = 0;
    end
    acc = '0;
    eng_in_ready = ($urandom_range(0, 99) < inr_pct);
    flush = force_flush || ($urandom_range(0, 999) < flush_pm);
    if (!out_hold) begin
      if (epipe.size() > 0 && epipe[0].due <= cyc &&
          $urandom_range(0, 99) < outv_pct) out_hold = 1;
      else if (orphan_now && epipe.size() == 0) out_hold = 1;
    end
    eng_out_valid = out_hold;
    for (int k = 0; k < 2 * SZ; k++) eng_result[k] = {$urandom, $urandom};
    if (epipe.size() > 0) begin
      eng_result[0] = epipe[0].re;
      eng_result[1] = epipe[0].im;
    end
    #3;
    any_v = |req_valid;
    g = lock_m ? lockid_m : pick(req_valid, rr_m);
    iss = any_v && (mq.size() < MAXO) && !flush;
    pu = iss && eng_in_ready;
    emp = (mq.size() == 0);
    hd = emp ? 0 : mq[0].id;
    po = !flush && eng_out_valid && !emp && rsp_ready[hd];
    exp_rdy = '0;
    if (pu) exp_rdy[g] = 1'b1;
    exp_rv = '0;
    if (!flush && eng_out_valid && !emp) exp_rv[hd] = 1'b1;
    chk("eng_in_valid", 64'(eng_in_valid), 64'(iss));
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (iss) chk("eng_operands", 64'(eng_ops == bundles[g]), 64'd1);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("eng_out_ready", 64'(eng_out_ready),
        64'(!flush && (emp || rsp_ready[hd])));
    chk("eng_flush", 64'(eng_flush), 64'(flush));
    chk("outstanding", 64'(outstanding), 64'(mq.size()));
    chk("busy", 64'(busy), 64'(any_v || !emp));
    chk("err", 64'(err), 64'(err_m));
    if (po) begin
      chk("rsp_re", rsp_result[0], mq[0].re);
      chk("rsp_im", rsp_result[1], mq[0].im);
      if (ph_single) begin
        chk("single_re", rsp_result[0], 64'hC054000000000000);
        chk("single_im", rsp_result[1], 64'h4064000000000000);
        single_seen++;
      end
    end
    // environment: requesters and engine react to the DUT
    acc = req_valid & req_ready;
    for (int r = 0; r < NR; r++) if (req_ready[r]) glog.push_back(r);
    if (req_ready[0]) pulses0++;
    if (eng_in_valid && eng_in_ready) begin
      t = mkexp(0, eng_ops);
      e.re = t.re;
      e.im = t.im;
      e.due = cyc + LAT;
      epipe.push_back(e);
    end
    if (eng_out_valid && eng_out_ready) begin
      if (epipe.size() > 0) epipe.delete(0);
      out_hold = 0;
    end
    if (eng_flush) begin
      epipe.delete();
      out_hold = 0;
    end
    // reference update at the coming edge
    if (flush) begin
      mq.delete();
      rr_m = 0;
      lock_m = 0;
    end else begin
      if (eng_out_valid && emp) err_m = 1;
      if (po) mq.delete(0);
      if (pu) begin
        mq.push_back(mkexp(g, bundles[g]));
        rr_m = (g + 1) % NR;
        lock_m = 0;
      end else if (iss && !lock_m) begin
        lock_m = 1;
        lockid_m = g;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    eng_in_ready = 1'b1;
    eng_out_valid = 1'b1;
    flush = 1'b1;
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_in_valid", 64'(eng_in_valid), 64'd0);
    chk("rst_out_ready", 64'(eng_out_ready), 64'd0);
    chk("rst_flush", 64'(eng_flush), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    eng_in_ready = 1'b0;
    eng_out_valid = 1'b0;
    flush = 1'b0;
    mq.delete();
    epipe.delete();
    rr_m = 0;
    lock_m = 0;
    err_m = 0;
    out_hold = 0;
    acc = '0;
  endtask

  initial begin
    for (int r = 0; r < NR; r++) new_bundle(r);
    do_reset();

    // single requester, all a=1+2j, b=3+4j
    for (int e = 0; e < SZ; e++) begin
      bundles[0][NO*e]   = $realtobits(1.0);
      bundles[0][NO*e+1] = $realtobits(2.0);
      bundles[0][NO*e+2] = $realtobits(3.0);
      bundles[0][NO*e+3] = $realtobits(4.0);
    end
    hold_mask = '0;
    nv = 4'b0001;
    nv_en = 1;
    ph_single = 1;
    repeat (10) step();
    ph_single = 0;
    chk("single_pulses", 64'(pulses0), 64'd1);
    chk("single_seen", 64'(single_seen), 64'd1);

    // fairness with all requesters held valid
    force_flush = 1;
    step();
    force_flush = 0;
    glog.delete();
    hold_mask = '1;
    nv = '1;
    nv_en = 1;
    repeat (20) step();
    for (int k = 0; k < 8; k++) begin
      if (k < glog.size()) chk("fair_order", 64'(glog[k]), 64'(k % NR));
      else chk("fair_count", 64'(glog.size()), 64'd8);
    end
    hold_mask = '0;
    nv = '0;
    nv_en = 1;
    repeat (8) step();

    // flush with three outstanding
    outv_pct = 0;
    hold_mask = '1;
    nv = '1;
    nv_en = 1;
    repeat (3) step();
    hold_mask = '0;
    nv = '0;
    nv_en = 1;
    force_flush = 1;
    step();
    force_flush = 0;
    step();
    chk("flush_cnt", 64'(outstanding), 64'd0);
    outv_pct = 100;

    // backpressure lock: 2 and 3 wait, 1 rises mid-wait
    glog.delete();
    inr_pct = 0;
    nv = 4'b1100;
    nv_en = 1;
    repeat (2) step();
    nv = 4'b1110;
    nv_en = 1;
    repeat (3) step();
    inr_pct = 100;
    repeat (6) step();
    chk("bp_count", 64'(glog.size()), 64'd3);
    if (glog.size() >= 3) begin
      chk("bp_first", 64'(glog[0]), 64'd2);
      chk("bp_second", 64'(glog[1]), 64'd3);
      chk("bp_third", 64'(glog[2]), 64'd1);
    end

    // full tracking FIFO with results held back
    force_flush = 1;
    step();
    force_flush = 0;
    glog.delete();
    rspr_pct = 0;
    hold_mask = '1;
    nv = '1;
    nv_en = 1;
    repeat (12) step();
    chk("full_accepts", 64'(glog.size()), 64'd8);
    chk("full_cnt", 64'(outstanding), 64'd8);
    rspr_pct = 100;
    step();
    rspr_pct = 0;
    step();
    chk("refill", 64'(glog.size()), 64'd9);
    hold_mask = '0;
    nv = '0;
    nv_en = 1;
    force_flush = 1;
    step();
    force_flush = 0;
    rspr_pct = 100;

    // orphan result, sticky across flush
    orphan_now = 1;
    step();
    orphan_now = 0;
    step();
    chk("orphan_err", 64'(err), 64'd1);
    force_flush = 1;
    step();
    force_flush = 0;
    step();
    chk("orphan_sticky", 64'(err), 64'd1);

    // random traffic, reset mid-run
    auto_req = 1;
    vprob = 40;
    inr_pct = 70;
    rspr_pct = 70;
    outv_pct = 70;
    flush_pm = 15;
    repeat (1500) step();
    do_reset();
    step();
    chk("err_cleared", 64'(err), 64'd0);
    repeat (600) step();
    auto_req = 0;
    flush_pm = 0;
    nv = '0;
    nv_en = 1;
    inr_pct = 100;
    rspr_pct = 100;
    outv_pct = 100;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdot_engine_arbiter.md
# cdot_engine_arbiter

Round-robin arbiter sharing one `complex_matrix_mul` complex dot-product engine among `NUM_REQ` requesters. It grants one requester's operand bundle per engine input handshake and records the requester ID in an in-order tracking FIFO. Each engine result is steered back to the requester that issued it. It sits between the matrix-level sequencers (one per output tile) and the single floating-point dot-product datapath.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `SIZE`, 16: complex elements per dot product; passed to the engine.
- `WIDTH`, 64: IEEE-754 double word width.
- `NUM_OPERANDS`, 4: words per element, ordered {a_re, a_im, b_re, b_im}.
- `MAX_OUTSTANDING`, 8: engine transactions in flight; power of 2, 2..32.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `flush_i`  in  1  synchronous abort of all in-flight work.
- `req_valid_i`  in  NUM_REQ  per-requester operand valid.
- `req_ready_o`  out  NUM_REQ  per-requester operand accept.
- `req_operands_i`  in  [NUM_REQ][SIZE*NUM_OPERANDS][WIDTH]  operand bundles.
- `rsp_valid_o`  out  NUM_REQ  per-requester result valid.
- `rsp_ready_i`  in  NUM_REQ  per-requester result accept.
- `rsp_result_o`  out  [2][WIDTH]  result broadcast to all requesters: word 0 real, word 1 imaginary.
- `eng_in_valid_o`  out  1  engine input valid.
- `eng_in_ready_i`  in  1  engine input ready.
- `eng_flush_o`  out  1  engine flush.
- `eng_operands_o`  out  [SIZE*NUM_OPERANDS][WIDTH]  granted bundle.
- `eng_out_valid_i`  in  1  engine result valid.
- `eng_out_ready_o`  out  1  engine result accept.
- `eng_result_i`  in  [2*SIZE][WIDTH]  engine result. Only words 0 and 1 are used.
- `outstanding_o`  out  $clog2(MAX_OUTSTANDING+1)  tracking-FIFO occupancy.
- `busy_o`  out  1  high when outstanding_o≠0 or any req_valid_i is high.
- `err_o`  out  1  sticky: engine produced a result while no transaction was tracked.

## Operation
- **Arbitration.** The round-robin pointer `rr_ptr` resets to 0. The winner is the lowest index ≥ `rr_ptr` with `req_valid_i` set, wrapping modulo `NUM_REQ`.
- **Issue.** Issue is allowed when some request is valid, FIFO not full, and `flush_i`=0. Then:
  - `eng_in_valid_o`=1 and `eng_operands_o` = the winner's bundle.
  - `req_ready_o[winner]` = `eng_in_ready_i`. All other `req_ready_o` bits are 0.
- **Grant FSM (IDLE/LOCKED).**
  - In IDLE, if `eng_in_valid_o`=1 and `eng_in_ready_i`=0, the FSM goes to LOCKED and registers the winner in `lock_id`.
  - In LOCKED, the grant is `lock_id` regardless of `rr_ptr`. This keeps `eng_operands_o` stable until the handshake.
  - On the handshake, the FSM returns to IDLE.
  - Requesters must hold valid and operands until accepted.
- **On each input handshake:**
  - Push the granted ID into the FIFO.
  - Set `rr_ptr` ← (granted+1) mod `NUM_REQ`.
- **Response routing.** Let `head` be the FIFO head ID.
  - `rsp_valid_o[head]` = `eng_out_valid_i` & FIFO non-empty.
  - `eng_out_ready_o` = `rsp_ready_i[head]`.
  - `rsp_result_o` = {`eng_result_i[1]`, `eng_result_i[0]`}.
  - Pop the FIFO on the output handshake.
- **Occupancy.** A push and a pop in the same cycle leave the occupancy unchanged. Issue is blocked only when occupancy equals `MAX_OUTSTANDING` at the start of the cycle. A same-cycle pop does not unblock it.
- **Orphan result** (`eng_out_valid_i`=1 while FIFO empty):
  - `eng_out_ready_o`=1, so the result is drained.
  - No `rsp_valid_o` is raised.
  - `err_o` is set and stays set until reset.
- **Flush.** While `flush_i`=1:
  - `eng_flush_o`=1 (combinational).
  - All `req_ready_o`, `rsp_valid_o`, `eng_in_valid_o` and `eng_out_ready_o` are 0.
  - At the clock edge: FIFO emptied, FSM→IDLE, `rr_ptr`→0.
  - `err_o` is unaffected.

## Timing
- Request path and response path add zero cycles; both are combinational pass-through. End-to-end latency equals the engine latency.
- State updates at posedge `clk_i`: FIFO, `rr_ptr`, FSM, `err_o`.
- Throughput: one issue per cycle and one response per cycle.
- Reset (asynchronous assert) and while `rst_ni`=0:
  - All valid/ready outputs, `eng_flush_o`, `busy_o`, `err_o` and `outstanding_o` are 0.
  - FIFO empty, `rr_ptr`=0, FSM IDLE.
- Reset mid-transaction discards all tracking. Results that reach the block after reset while the FIFO is empty follow the orphan rule.
- Outputs first become active in the first cycle after `rst_ni` rises.

## Test plan
- **Single requester.** Requester 0 sends 16 elements, all a=1+2j, b=3+4j. Required: `req_ready_o[0]` pulses once; `rsp_valid_o[0]` returns -80+160j (0xC054000000000000, 0x4064000000000000); `outstanding_o` goes 1→0.
- **Fairness.** All 4 requesters hold valid continuously with `eng_in_ready_i`=1. Required: grant order 0,1,2,3,0,1…; each result is routed to its issuer in issue order.
- **Backpressure lock.** Requesters 2 and 3 are valid, `eng_in_ready_i`=0 for 5 cycles, and requester 1 rises mid-wait. Required: `eng_operands_o` stays requester 2's bundle; the next grant is 3, then 1.
- **Full FIFO.** `MAX_OUTSTANDING`=8, engine output stalled (`rsp_ready_i`=0). Required: exactly 8 accepts, then all `req_ready_o`=0 and `outstanding_o`=8; a single pop re-enables issue on the following cycle.
- **Flush.** Flush with 3 transactions outstanding. Required: `eng_flush_o`=1 that cycle; `outstanding_o`=0 and `rr_ptr`=0 next cycle; no `rsp_valid_o` for the flushed work.
- **Orphan / reset.** Drive `eng_out_valid_i`=1 with the FIFO empty. Required: `eng_out_ready_o`=1, no `rsp_valid_o`, `err_o`=1 sticky across flush; `err_o` cleared only by `rst_ni`=0.
